// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// i2c_req_arbiter : round-robin sharing of one I2C master among NUM_REQ clients
// Rev 1.0 - initial release
// ============================================================================
module i2c_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [7*NUM_REQ-1:0]       i_req_addr,
  input  logic [NUM_REQ-1:0]         i_req_rw,
  input  logic [8*NUM_REQ-1:0]       i_req_wdata,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [NUM_REQ-1:0]         o_rsp_valid,
  output logic [7:0]                 o_rsp_rdata,
  output logic [1:0]                 o_rsp_err,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_m_start,
  output logic [6:0]                 o_m_addr,
  output logic                       o_m_rw,
  output logic [7:0]                 o_m_data,
  input  logic                       i_m_busy,
  input  logic                       i_m_done,
  input  logic                       i_m_nack,
  input  logic [7:0]                 i_m_rdata
);

  localparam int              c_IW   = $clog2(NUM_REQ);
  localparam int              c_TW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_run;
  logic [c_IW-1:0] r_ptr;
  logic [c_IW-1:0] r_grant;
  logic [c_TW-1:0] r_timer;
  logic [6:0]      r_addr;
  logic            r_rw;
  logic [7:0]      r_data;
  logic [7:0]      r_rsp_rdata;
  logic [1:0]      r_rsp_err;

  logic [c_IW-1:0] w_pick;
  logic [c_IW-1:0] w_cand;
  logic            w_any;
  logic            w_accept;
  logic            w_timeout;
  logic [6:0]      w_sel_addr;
  logic            w_sel_rw;
  logic [7:0]      w_sel_data;
  int              w_k;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_pick = '0;
    w_cand = '0;
    w_any  = 1'b0;
    w_k    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_k = int'(r_ptr) + i;
      if (w_k >= NUM_REQ) w_k = w_k - NUM_REQ;
      w_cand = c_IW'(w_k);
      if (i_req_valid[w_cand]) begin
        w_pick = w_cand;
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_rw   = 1'b0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == c_IW'(i)) begin
        w_sel_addr = i_req_addr[7*i +: 7];
        w_sel_rw   = i_req_rw[i];
        w_sel_data = i_req_wdata[8*i +: 8];
      end
    end
  end

  // r_run keeps the first cycle after reset release from granting.
  assign w_accept = (r_state == S_IDLE) && r_run && !i_m_busy && w_any;

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_wdog
      assign w_timeout = 1'b0;
    end else begin : g_wdog
      assign w_timeout = (r_timer == c_TW'(TIMEOUT_CYC - 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    o_rsp_valid = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          o_req_ready[w_pick] = 1'b1;
          w_state_nxt         = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (i_m_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP: begin
        o_rsp_valid[r_grant] = 1'b1;
        w_state_nxt          = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_timer     <= '0;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_data      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_grant <= w_pick;
        r_addr  <= w_sel_addr;
        r_rw    <= w_sel_rw;
        r_data  <= w_sel_data;
      end
      if (r_state == S_ISSUE)     r_timer <= '0;
      else if (r_state == S_WAIT) r_timer <= r_timer + 1'b1;
      // m_done has priority over a coincident watchdog expiry.
      if (r_state == S_WAIT) begin
        if (i_m_done) begin
          r_rsp_err   <= {1'b0, i_m_nack};
          r_rsp_rdata <= (r_rw && !i_m_nack) ? i_m_rdata : 8'h00;
        end else if (w_timeout) begin
          r_rsp_err   <= 2'b10;
          r_rsp_rdata <= 8'h00;
        end
      end
      if (r_state == S_RESP) r_ptr <= (r_grant == c_LAST) ? '0 : r_grant + 1'b1;
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_m_start   = (r_state == S_ISSUE);
  assign o_grant_id  = r_grant;
  assign o_m_addr    = r_addr;
  assign o_m_rw      = r_rw;
  assign o_m_data    = r_data;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// Directed bench for i2c_req_arbiter: stimulus drives at the falling edge,
// the bench plays the I2C master and checks against hand-computed values.
module tb_i2c_req_arbiter;
  localparam int N = 4;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [7*N-1:0] req_addr  = '0;
  logic [N-1:0]   req_rw    = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic           m_busy    = 1'b0;
  logic           m_done    = 1'b0;
  logic           m_nack    = 1'b0;
  logic [7:0]     m_rdata   = 8'h00;

  logic [N-1:0] rdy, rsp_valid;
  logic [7:0]   rsp_rdata, m_data;
  logic [1:0]   rsp_err, gid;
  logic         busy, m_start, m_rw;
  logic [6:0]   m_addr;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(64)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_rw(req_rw), .i_req_wdata(req_wdata),
    .o_req_ready(rdy), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_busy(busy), .o_grant_id(gid), .o_m_start(m_start), .o_m_addr(m_addr),
    .o_m_rw(m_rw), .o_m_data(m_data), .i_m_busy(m_busy), .i_m_done(m_done),
    .i_m_nack(m_nack), .i_m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic post(input int id, input logic [6:0] a, input logic rw, input logic [7:0] d);
    req_addr[7*id +: 7]  = a;
    req_rw[id]           = rw;
    req_wdata[8*id +: 8] = d;
    req_valid[id]        = 1'b1;
  endtask

  // dly < 0: master never answers, watchdog latency is checked instead.
  task automatic txn(input int id, input logic [6:0] a, input logic rw, input logic [7:0] d,
                     input int dly, input logic nack, input logic [7:0] rd,
                     input logic [1:0] e_err, input logic [7:0] e_rd);
    int n;
    logic [N-1:0] exp_oh;
    logic [N-1:0] g_oh;
    exp_oh     = '0;
    exp_oh[id] = 1'b1;
    n = 0;
    while (rdy == '0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready", 32'(rdy), 32'(exp_oh));
    g_oh = rdy;
    @(negedge clk);
    req_valid = req_valid & ~g_oh;
    #1;
    chk("m_start", 32'(m_start), 32'd1);
    chk("m_addr", 32'(m_addr), 32'(a));
    chk("m_rw", 32'(m_rw), 32'(rw));
    chk("m_data", 32'(m_data), 32'(d));
    chk("grant_id", 32'(gid), 32'(id));
    @(negedge clk);
    if (dly < 0) begin
      n = 0;
      while (rsp_valid == '0 && n < 200) begin
        @(negedge clk); #1;
        n++;
      end
      chk("to_latency", 32'(n), 32'd64);
    end else begin
      repeat (dly) @(negedge clk);
      m_done = 1'b1; m_nack = nack; m_rdata = rd;
      @(negedge clk);
      m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
      #1;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, {rdy, rsp_valid, rsp_rdata, rsp_err, busy, gid, m_start}, 32'd0);
    chk({tag, "_b"}, {m_addr, m_rw, m_data}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Master busy holds the arbiter off.
    m_busy = 1'b1;
    post(0, 7'h10, 1'b0, 8'h01);
    repeat (3) @(negedge clk);
    #1;
    chk("busy_hold", 32'(rdy), 32'd0);
    m_busy = 1'b0;
    #1;
    // Write: read byte on the bus must not leak into rsp_rdata.
    txn(0, 7'h10, 1'b0, 8'h01, 20, 1'b0, 8'hFF, 2'b00, 8'h00);
    @(negedge clk); #1;
    chk("idle_after", 32'(busy), 32'd0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with everyone pending, then wrap 3->0 with only 0 and 2.
    for (int i = 0; i < N; i++) post(i, 7'(32'h20 + i), 1'b0, 8'(32'h30 + i));
    for (int i = 0; i < N; i++) txn(i, 7'(32'h20 + i), 1'b0, 8'(32'h30 + i), 2 + i, 1'b0, 8'h00, 2'b00, 8'h00);
    post(0, 7'h11, 1'b0, 8'h40);
    post(2, 7'h12, 1'b0, 8'h41);
    txn(0, 7'h11, 1'b0, 8'h40, 1, 1'b0, 8'h00, 2'b00, 8'h00);
    txn(2, 7'h12, 1'b0, 8'h41, 0, 1'b0, 8'h00, 2'b00, 8'h00);

    post(1, 7'h48, 1'b1, 8'h00);
    txn(1, 7'h48, 1'b1, 8'h00, 5, 1'b0, 8'hA5, 2'b00, 8'hA5);
    post(1, 7'h48, 1'b1, 8'h00);
    txn(1, 7'h48, 1'b1, 8'h00, 3, 1'b1, 8'h5A, 2'b01, 8'h00);

    post(2, 7'h50, 1'b1, 8'h00);
    txn(2, 7'h50, 1'b1, 8'h00, -1, 1'b0, 8'h00, 2'b10, 8'h00);
    post(2, 7'h51, 1'b1, 8'h00);
    txn(2, 7'h51, 1'b1, 8'h00, 63, 1'b0, 8'h3C, 2'b00, 8'h3C);

    // Reset while waiting on the master.
    post(3, 7'h33, 1'b0, 8'h77);
    n = 0;
    while (rdy == '0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("r6_ready", 32'(rdy), 32'h8);
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    #1;
    chk("r6_busy", 32'(busy), 32'd1);
    post(0, 7'h01, 1'b0, 8'hC0);
    post(3, 7'h33, 1'b0, 8'h77);
    rst_n = 1'b0;
    #1;
    chk_zero("r6_async");
    m_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("r6_no_rsp", 32'(rsp_valid), 32'd0);
    end
    m_done = 1'b0;
    rst_n  = 1'b1;
    txn(0, 7'h01, 1'b0, 8'hC0, 2, 1'b0, 8'h00, 2'b00, 8'h00);
    txn(3, 7'h33, 1'b0, 8'h77, 2, 1'b1, 8'h00, 2'b01, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
